instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Parametrised, loadable instruction memory for the 16-bit ThinPad CPU fetch stage.
- Replaces the fixed, reset-initialised program pool with three capabilities:
  - a hardware clear on reset;
  - a streaming program-load port with a ready/valid handshake (fed by the UART bootloader);
  - a registered, stall-aware fetch port with NOP injection on memory conflict or out-of-range PC.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
- DATA_W, 16, instruction width in bits.
- ADDR_W, 6, memory index width.
- DEPTH, 64, number of words. Must be at most 2^ADDR_W.
- NOP_WORD, 16'h0800, word injected for bubbles and unloaded locations.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- pc  input  16  word-addressed fetch PC.
- fetch_en  input  1  fetch request in the RUN state.
- stall  input  1  pipeline stall; holds the fetch output.
- mem_conflict  input  1  data access owns the memory bus this cycle.
- instr  output  DATA_W  fetched instruction, registered.
- instr_valid  output  1  instr is meaningful this cycle.
- pc_oor  output  1  the PC was at or above prog_len; NOP was issued.
- load_start  input  1  request to enter LOAD.
- load_valid  input  1  load_data is valid.
- load_data  input  DATA_W  program word.
- load_last  input  1  qualifies the final load word.
- load_ready  output  1  loader may present a word.
- load_err  output  1  sticky; a word arrived with the memory full.
- busy  output  1  high in the CLEAR and LOAD states.
- prog_len  output  ADDR_W+1  number of words loaded.

Behaviour:
- Reset (rst==0 at a clock edge):
  - state goes to CLEAR; clear counter goes to 0;
  - instr=NOP_WORD, instr_valid=0, pc_oor=0, load_ready=0, load_err=0, prog_len=0, busy=1;
  - reset overrides every other input, in any state, including mid-load.
- CLEAR:
  - writes NOP_WORD to mem[cnt] each cycle; cnt increments;
  - at cnt==DEPTH-1 the write completes and the state goes to RUN;
  - takes exactly DEPTH cycles;
  - fetch and load inputs are ignored; load_start is not remembered.
- RUN, fetch path with 1-cycle latency. Priority each edge:
  1. stall=1: instr, instr_valid and pc_oor hold.
  2. Else mem_conflict=1: instr=NOP_WORD, instr_valid=1, pc_oor=0.
  3. Else fetch_en=1 and pc<prog_len: instr=mem[pc[ADDR_W-1:0]], instr_valid=1, pc_oor=0.
  4. Else fetch_en=1 and pc>=prog_len: instr=NOP_WORD, instr_valid=1, pc_oor=1.
  5. Else: instr_valid=0, instr holds.
- PC comparison:
  - uses all 16 bits, compared against prog_len zero-extended to 16 bits;
  - there is no modulo wrap, so pc=DEPTH+k is out of range and never aliases.
- RUN, load entry:
  - load_start=1 with stall=0 enters LOAD next cycle;
  - on entry: write pointer=0, prog_len=0, load_err cleared, instr_valid=0;
  - load_start while stall=1 is ignored;
  - load_start has priority over fetch_en in the same cycle; the fetch is dropped and instr_valid=0.
- LOAD:
  - load_ready=1 whenever in LOAD.
  - A word is accepted on load_valid && load_ready:
    - if wptr<DEPTH: mem[wptr]=load_data, wptr++, prog_len=wptr+1;
    - if wptr==DEPTH: the word is dropped, load_err=1, prog_len stays DEPTH.
  - Acceptance with load_last=1 stores or drops the word under the rules above, then goes to RUN next cycle with load_ready=0.
  - load_last without load_valid has no effect.
  - Locations at or above prog_len keep their old contents; these are masked by the pc_oor rule.
  - A repeated load_start in LOAD is ignored.
- Memory:
  - single-port array of DEPTH x DATA_W;
  - CLEAR and LOAD writes are exclusive with RUN reads by state, so there is no read-during-write case;
  - synchronous read is permitted (block RAM inference).
- busy = (state != RUN).

Decomposition:
- Shared package isa_pkg:
  - NOP_WORD, DATA_W and the opcode constants for the fetch/decode path;
  - state enum {CLEAR, LOAD, RUN} as a 2-bit localparam set.
- One natural sub-module: imem_ram. It holds the DEPTH x DATA_W array with one write port (we, waddr, wdata) and one synchronous read port (re, raddr, rdata).
- The controller FSM, counters and fetch mux stay in instr_mem_loader.

Test Plan:
- Reset, then release rst.
  - busy=1 for exactly 64 cycles, then 0.
  - In RUN, fetch pc=0 → instr=16'h0800, instr_valid=1, pc_oor=1 (prog_len=0).
- load_start, then stream 3 words 16'h69BF, 16'h3120, 16'h9940 (last on the third).
  - prog_len=3, back in RUN.
  - Fetching pc=0,1,2 returns those words one cycle later; pc=3 → 16'h0800 with pc_oor=1.
- Fetch pc=1 with mem_conflict=1 → instr=16'h0800, instr_valid=1, pc_oor=0.
  - Next cycle, with the conflict low → 16'h3120.
- Fetch pc=2, then assert stall for 4 cycles while pc changes to 0 → instr stays 16'h9940 throughout.
  - After release → 16'h69BF.
- Load 65 words with DEPTH=64.
  - load_err=1 after word 65 and prog_len=64.
  - mem[63] holds word 64; pc=64 → NOP with pc_oor=1.
- Assert rst low in the middle of a load (after word 2).
  - Next cycle: busy=1, load_ready=0, prog_len=0, instr_valid=0.
  - After CLEAR, fetch pc=0 → NOP with pc_oor=1.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ThinPad ISA constants and fetch-path types for the instruction memory.
package isa_pkg;

    localparam int          DATA_W   = 16;
    localparam int          PC_W     = 16;
    localparam logic [15:0] NOP_WORD = 16'h0800;

    // Major opcode field (instr[15:11]) values seen on the fetch/decode path.
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_ADDIU = 5'b01001;
    localparam logic [4:0] OP_LI   = 5'b01101;
    localparam logic [4:0] OP_LW   = 5'b10011;
    localparam logic [4:0] OP_SW   = 5'b11011;
    localparam logic [4:0] OP_B    = 5'b00010;

    // Loader controller states.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Fetch and program-load signal bundle between the CPU/bootloader and the
// loadable instruction memory.
interface instr_mem_loader_if
    import isa_pkg::*;
#(
    parameter int DATA_W = isa_pkg::DATA_W,
    parameter int ADDR_W = 6
);
    // fetch side
    logic [PC_W-1:0]   pc;
    logic              fetch_en;
    logic              stall;
    logic              mem_conflict;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              pc_oor;
    // load side
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_err;
    // status
    logic              busy;
    logic [ADDR_W:0]   prog_len;

    modport master (
        output pc, fetch_en, stall, mem_conflict,
        output load_start, load_valid, load_data, load_last,
        input  instr, instr_valid, pc_oor, load_ready, load_err, busy, prog_len
    );

    modport slave (
        input  pc, fetch_en, stall, mem_conflict,
        input  load_start, load_valid, load_data, load_last,
        output instr, instr_valid, pc_oor, load_ready, load_err, busy, prog_len
    );

endinterface

// File: rtl/imem_ram.sv
// DEPTH x DATA_W instruction store: one write port, one synchronous read port.
// Read data holds when re is low, which the fetch path relies on for stalls.
module imem_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: clear sweep and program load.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Registered read port; output holds while re is low.
    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loadable instruction memory for the ThinPad fetch stage: clears itself after
// reset, accepts a streamed program from the bootloader, and serves a
// registered, stall-aware fetch with NOP injection.
module instr_mem_loader
    import isa_pkg::*;
#(
    parameter int          DATA_W   = isa_pkg::DATA_W,
    parameter int          ADDR_W   = 6,
    parameter int          DEPTH    = 64,
    parameter logic [15:0] NOP_WORD = isa_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    instr_mem_loader_if.slave  bus
);

    localparam logic [ADDR_W-1:0] CNT_LAST = (ADDR_W)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] NOP_D    = (DATA_W)'(NOP_WORD);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    // prog_len doubles as the load write pointer: they are always equal.
    logic [ADDR_W:0]   len_q;
    logic              err_q;
    logic              vld_q;
    logic              oor_q;
    // instr comes from the RAM read register when set, otherwise it is NOP.
    logic              sel_ram_q;

    logic              run, in_range, enter_load, accept, full;
    logic              fetch_hit;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    assign run        = (state == ST_RUN);
    assign in_range   = bus.pc < PC_W'(len_q);
    assign enter_load = run && bus.load_start && !bus.stall;
    assign accept     = (state == ST_LOAD) && bus.load_valid;
    assign full       = (len_q == LEN_FULL);
    assign fetch_hit  = run && !bus.stall && !bus.load_start && !bus.mem_conflict
                        && bus.fetch_en && in_range;

    // Memory port steering: CLEAR sweeps NOPs, LOAD stores accepted words,
    // RUN only reads, so reads and writes never overlap.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cnt;
        ram_wdata = NOP_D;
        if (state == ST_CLEAR) begin
            ram_we = 1'b1;
        end else if (accept && !full) begin
            ram_we    = 1'b1;
            ram_waddr = len_q[ADDR_W-1:0];
            ram_wdata = bus.load_data;
        end
    end

    assign ram_re = fetch_hit;

    imem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (bus.pc[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // Next-state logic for the CLEAR -> RUN <-> LOAD controller.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (cnt == CNT_LAST) state_nxt = ST_RUN;
            ST_RUN:   if (enter_load) state_nxt = ST_LOAD;
            ST_LOAD:  if (accept && bus.load_last) state_nxt = ST_RUN;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // State register, counters and fetch output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_CLEAR;
            cnt       <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            vld_q     <= 1'b0;
            oor_q     <= 1'b0;
            sel_ram_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_CLEAR: begin
                    cnt   <= cnt + 1'b1;
                    vld_q <= 1'b0;
                end
                ST_LOAD: begin
                    vld_q <= 1'b0;
                    if (accept) begin
                        if (!full) len_q <= len_q + 1'b1;
                        else       err_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.stall) begin
                        // hold instr, instr_valid and pc_oor
                    end else if (bus.load_start) begin
                        len_q <= '0;
                        err_q <= 1'b0;
                        vld_q <= 1'b0;
                    end else if (bus.mem_conflict) begin
                        vld_q     <= 1'b1;
                        oor_q     <= 1'b0;
                        sel_ram_q <= 1'b0;
                    end else if (bus.fetch_en) begin
                        vld_q     <= 1'b1;
                        oor_q     <= !in_range;
                        sel_ram_q <= in_range;
                    end else begin
                        vld_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instr       = sel_ram_q ? ram_rdata : NOP_D;
    assign bus.instr_valid = vld_q;
    assign bus.pc_oor      = oor_q;
    assign bus.load_ready  = (state == ST_LOAD);
    assign bus.load_err    = err_q;
    assign bus.busy        = !run;
    assign bus.prog_len    = len_q;

endmodule
